sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Producer side of the Sobel lane datapath.
- Accepts a raster RGB888 pixel stream, buffers two previous lines and maintains a 3x3 sliding window.
- Emits one packed window per interior pixel to the G_x/G_y arithmetic lanes, which take window pixels as +1/+2/-1/-2 operands.
- Valid/ready on both sides; one output register stage.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).
- PIX_W, 24, pixel width, RGB888 packed as R[23:16] G[15:8] B[7:0].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid&&in_ready.
- in_pixel  in  PIX_W  raster-order pixel.
- in_sof  in  1  marks the accepted pixel as (x=0,y=0).
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- out_window  out  9*PIX_W  element (r,c) at bits [(r*3+c)*PIX_W +: PIX_W]; r=0 oldest row, c=0 leftmost column; centre is (1,1).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset=0, async) forces:
  - out_valid=0, out_window=0, frame_done=0;
  - col=0, row=0, state=IDLE.
  - Line-buffer contents are don't-care.
- in_ready = !out_valid || out_ready, in every state.
- States:
  - IDLE: accepted pixels without in_sof are discarded. A pixel with in_sof is processed as (0,0); go to FILL.
  - FILL: rows 0-1 stored, no windows emitted. Go to RUN when the first pixel of row 2 is accepted.
  - RUN: the window is emitted as described below. After pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted, frame_done=1 next cycle and state goes to IDLE.
- Per accepted pixel at (col,row):
  - linebuf1[col] -> linebuf0[col]; in_pixel -> linebuf1[col]. Reads at the same address see the old value (read-before-write).
  - The window shifts left by one column. New right column is {linebuf0[col], linebuf1[col], in_pixel} for rows 0, 1, 2.
  - col increments. At IMG_WIDTH-1 it wraps to 0 and row increments.
- The window is loaded into out_window with out_valid=1 on the cycle after acceptance, iff row>=2 && col>=2.
  - The window then holds pixels (col-2..col, row-2..row); its centre is (col-1, row-1).
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - No windows straddle line boundaries; the window registers restart at each col=0.
- If the accepted pixel yields no window, out_valid clears on that edge when out_ready=1.
- Backpressure: while out_valid && !out_ready, out_window and out_valid hold and in_ready=0. No pixel is lost or duplicated.
- in_sof in any state: the pixel is treated as (0,0) of a new frame and state goes to FILL. Any partial frame is abandoned, with no frame_done. A pending out_valid window is still delivered normally.
- Latency: 1 cycle from acceptance of pixel (x,y) to out_valid for centre (x-1,y-1).
- Counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits wide. No arithmetic on pixel data.

Optional Feature:
- SOBEL_WIN_COORD_EN defined:
  - Adds outputs out_x [$clog2(IMG_WIDTH)] and out_y [$clog2(IMG_HEIGHT)], giving the window centre coordinates.
  - Registered with out_window and held under backpressure; reset to 0.
- Undefined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Setup for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4, pixel(x,y) = {8'(y), 8'(x), 8'hA5}.
- Reset: assert reset mid-stream -> out_valid=0, frame_done=0, in_ready=1 immediately (async), IDLE. After release, 3 pixels without in_sof produce no output.
- Full frame, in_valid=1, out_ready=1, in_sof on first pixel -> exactly 4 windows, centres (1,1), (2,1), (1,2), (2,2).
  - First out_valid comes 1 cycle after accepting (2,2); window element (0,0) = pixel(0,0) and element (2,2) = pixel(2,2).
  - frame_done pulses once, 1 cycle after pixel (3,3).
- Backpressure: out_ready=0 for 5 cycles at the first window -> out_window and out_valid stable, in_ready=0. After release, the remaining 3 windows are correct with no gaps in data.
- Re-sync: in_sof asserted on the 7th pixel of a frame -> no frame_done for the abandoned frame. The next window is centre (1,1) of the new frame, after 11 further pixels.
- Idle input gaps: in_valid toggling 1/0 every cycle over a full frame -> same 4 windows and same contents as the continuous case.
- With SOBEL_WIN_COORD_EN: full frame -> out_x/out_y = (1,1), (2,1), (1,2), (2,2) in order, held under backpressure.

Source files
------------

// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Producer side of the Sobel lane datapath. Takes a raster RGB888 pixel
//   stream, keeps the two previous lines in line buffers and a 3x3 sliding
//   window, and emits one packed window per interior pixel to the G_x/G_y
//   lanes. Valid/ready handshakes on both sides, one output register stage.
//
//   Ports:
//     clk, reset      - clock, asynchronous active-low reset
//     in_valid/ready  - input pixel handshake
//     in_pixel        - raster-order pixel, R[23:16] G[15:8] B[7:0]
//     in_sof          - accepted pixel is (0,0) of a new frame
//     out_valid/ready - window handshake
//     out_window      - element (r,c) at [(r*3+c)*PIX_W +: PIX_W],
//                       r=0 oldest row, c=0 leftmost column
//     frame_done      - one-cycle pulse after the last pixel of a frame
//
//   Optional build macro SOBEL_WIN_COORD_EN adds out_x/out_y, the centre
//   coordinates of the window on out_window.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_pixel,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*PIX_W-1:0]   out_window,
    output logic                 frame_done
`ifdef SOBEL_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next, pos_col;
    logic [RW-1:0]   row_reg, row_next, pos_row;
    logic            accept, process, emit, last_pix, fd_next;

    logic [PIX_W-1:0]   linebuf0 [IMG_WIDTH];
    logic [PIX_W-1:0]   linebuf1 [IMG_WIDTH];
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;
    logic [PIX_W-1:0]   new_col [3];
    logic [9*PIX_W-1:0] win_reg, win_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // In IDLE only a start-of-frame pixel is taken into the datapath.
    assign process  = accept && (in_sof || state_reg != IDLE);
    // in_sof overrides the counters so a resync pixel lands at (0,0).
    assign pos_col  = in_sof ? '0 : col_reg;
    assign pos_row  = in_sof ? '0 : row_reg;
    assign last_pix = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
    // Window registers only hold a full window once three columns of the
    // current line have shifted in, so col>=2 also keeps windows from
    // straddling line boundaries.
    assign emit     = process && (pos_col >= CW'(2)) && (pos_row >= RW'(2));

    // Next-state / counter logic
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        fd_next    = 1'b0;
        if (process) begin
            if (pos_col == COL_LAST) begin
                col_next = '0;
                row_next = last_pix ? '0 : pos_row + 1'b1;
            end else begin
                col_next = pos_col + 1'b1;
                row_next = pos_row;
            end
            case (state_reg)
                IDLE: state_next = IDLE;
                FILL: if (pos_col == '0 && pos_row == RW'(2)) state_next = RUN;
                RUN: begin
                    if (last_pix) begin
                        state_next = IDLE;
                        fd_next    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            // A new frame always restarts filling; a partial frame is
            // abandoned without frame_done.
            if (in_sof) begin
                state_next = FILL;
                fd_next    = 1'b0;
            end
        end
    end

    // Line buffers use asynchronous read: the new window column has to be
    // formed in the same cycle the pixel is accepted. The read sees the old
    // contents of the address being written (read-before-write).
    assign lb0_rd = linebuf0[pos_col];
    assign lb1_rd = linebuf1[pos_col];

    always_ff @(posedge clk) begin
        if (process) begin
            linebuf0[pos_col] <= lb1_rd;
            linebuf1[pos_col] <= in_pixel;
        end
    end

    assign new_col[0] = lb0_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = in_pixel;

    // Shift the window left by one column and insert the new right column.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign win_next[(gi*3+0)*PIX_W +: PIX_W] = win_reg[(gi*3+1)*PIX_W +: PIX_W];
            assign win_next[(gi*3+1)*PIX_W +: PIX_W] = win_reg[(gi*3+2)*PIX_W +: PIX_W];
            assign win_next[(gi*3+2)*PIX_W +: PIX_W] = new_col[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (process) win_reg <= win_next;
    end

    // Control state and output register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            col_reg    <= '0;
            row_reg    <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            frame_done <= 1'b0;
`ifdef SOBEL_WIN_COORD_EN
            out_x      <= '0;
            out_y      <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            frame_done <= fd_next;
            // Output stage only moves when it is empty or being drained.
            if (in_ready) begin
                out_valid <= emit;
                if (emit) begin
                    out_window <= win_next;
`ifdef SOBEL_WIN_COORD_EN
                    out_x      <= pos_col - 1'b1;
                    out_y      <= pos_row - 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen: 4x4 image, pixel(x,y) = {y, x, 8'hA5}.
// Expected windows are built from pixel coordinates and queued when the
// producing pixel is accepted; a monitor pops and compares each delivered
// window.
module tb_sobel_window_gen;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int PW   = 24;
    localparam int WINW = 9 * PW;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_pixel;
    logic            in_sof;
    logic            out_valid;
    logic            out_ready;
    logic [WINW-1:0] out_window;
    logic            frame_done;
`ifdef SOBEL_WIN_COORD_EN
    logic [1:0]      out_x;
    logic [1:0]      out_y;
`endif

    int tests   = 0;
    int fails   = 0;
    int win_seen = 0;
    int fd_seen  = 0;
    logic [WINW-1:0] exp_q[$];
    int              cx_q[$];
    int              cy_q[$];
    logic [WINW-1:0] mon_exp;
    int              mon_cx, mon_cy;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .in_sof(in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_window(out_window),
        .frame_done(frame_done)
`ifdef SOBEL_WIN_COORD_EN
        ,
        .out_x(out_x),
        .out_y(out_y)
`endif
    );

    function automatic logic [PW-1:0] pix(int x, int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
        return {yb, xb, 8'hA5};
    endfunction

    function automatic logic [WINW-1:0] model_win(int x, int y);
        logic [WINW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*PW +: PW] = pix(x - 2 + c, y - 2 + r);
        return w;
    endfunction

    task automatic chk(string tag, logic [WINW-1:0] obs, logic [WINW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: one transfer per falling edge where valid && ready.
    always @(negedge clk) begin
        if (reset && frame_done) fd_seen++;
        if (reset && out_valid && out_ready) begin
            chk("window_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_cx  = cx_q.pop_front();
                mon_cy  = cy_q.pop_front();
                chk("window_data", out_window, mon_exp);
`ifdef SOBEL_WIN_COORD_EN
                chk("window_x", out_x, mon_cx);
                chk("window_y", out_y, mon_cy);
`endif
                win_seen++;
                $display("[TB] window %0d centre (%0d,%0d) window=%0h", win_seen, mon_cx, mon_cy, out_window);
            end
        end
    end

    // Drive one pixel; live=1 when the DUT should treat it as frame data.
    task automatic send(int x, int y, bit sof, bit live, bit exp_fd);
        bit got;
        bit exp_win;
        exp_win  = live && x >= 2 && y >= 2;
        in_valid = 1'b1;
        in_pixel = pix(x, y);
        in_sof   = sof;
        got      = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        chk("in_ready_wait", got, 1);
        if (got) begin
            if (exp_win) begin
                exp_q.push_back(model_win(x, y));
                cx_q.push_back(x - 1);
                cy_q.push_back(y - 1);
            end
            @(posedge clk);
            #1;
            chk("out_valid_after_accept", out_valid, exp_win);
            chk("frame_done_after_accept", frame_done, exp_fd);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send(x, y, x == 0 && y == 0, 1'b1, x == W-1 && y == H-1);
                if (gaps) begin
                    @(posedge clk);
                    #1;
                end
            end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int w0, f0;
        logic [WINW-1:0] cap;
`ifdef SOBEL_WIN_COORD_EN
        logic [1:0] capx, capy;
`endif
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_window", out_window, 0);
        reset = 1'b1;

        // Reset asserted mid-stream while a window is held.
        for (int i = 0; i < 11; i++) begin
            if (i == 10) out_ready = 1'b0;
            send(i % W, i / W, i == 0, 1'b1, 1'b0);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_frame_done", frame_done, 0);
        chk("async_reset_in_ready", in_ready, 1);
        exp_q.delete();
        cx_q.delete();
        cy_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // IDLE discards pixels without in_sof.
        w0 = win_seen;
        send(2, 2, 1'b0, 1'b0, 1'b0);
        send(3, 2, 1'b0, 1'b0, 1'b0);
        send(2, 3, 1'b0, 1'b0, 1'b0);
        drain();
        chk("idle_no_windows", win_seen - w0, 0);

        // Full frame, continuous.
        w0 = win_seen;
        f0 = fd_seen;
        send_frame(1'b0);
        drain();
        chk("full_window_count", win_seen - w0, 4);
        chk("full_frame_done_count", fd_seen - f0, 1);

        // Backpressure at the first window.
        w0 = win_seen;
        f0 = fd_seen;
        for (int i = 0; i < W*H; i++) begin
            if (i == 10) out_ready = 1'b0;
            send(i % W, i / W, i == 0, 1'b1, i == W*H-1);
            if (i == 10) begin
                cap = out_window;
`ifdef SOBEL_WIN_COORD_EN
                capx = out_x;
                capy = out_y;
`endif
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_window_hold", out_window, cap);
`ifdef SOBEL_WIN_COORD_EN
                    chk("bp_x_hold", out_x, capx);
                    chk("bp_y_hold", out_y, capy);
`endif
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        end
        drain();
        chk("bp_window_count", win_seen - w0, 4);
        chk("bp_frame_done_count", fd_seen - f0, 1);

        // Resync: in_sof on the 7th pixel abandons the partial frame.
        w0 = win_seen;
        f0 = fd_seen;
        for (int i = 0; i < 6; i++) send(i % W, i / W, i == 0, 1'b1, 1'b0);
        send_frame(1'b0);
        drain();
        chk("resync_window_count", win_seen - w0, 4);
        chk("resync_frame_done_count", fd_seen - f0, 1);

        // Idle gaps on the input every other cycle.
        w0 = win_seen;
        f0 = fd_seen;
        send_frame(1'b1);
        drain();
        chk("gaps_window_count", win_seen - w0, 4);
        chk("gaps_frame_done_count", fd_seen - f0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "time limit reached");
    end

endmodule
